// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_pkg
//  Purpose  : Shared state codes, MIPS-lite opcode/func constants, control
//             field encodings and the decoded instruction-class bundle.
//  Revision : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDU    = 3'd5
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] c_F_JR    = 6'b001000;
    localparam logic [5:0] c_F_MFHI  = 6'b010000;
    localparam logic [5:0] c_F_MFLO  = 6'b010010;
    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;
    localparam logic [5:0] c_F_ADDU  = 6'b100001;
    localparam logic [5:0] c_F_SUBU  = 6'b100011;

    // ALU operation codes (zero-extended to the aluctr width at the top)
    localparam logic [1:0] c_ALU_ADD = 2'd0;
    localparam logic [1:0] c_ALU_SUB = 2'd1;
    localparam logic [1:0] c_ALU_OR  = 2'd2;
    localparam logic [1:0] c_ALU_LUI = 2'd3;

    localparam logic [1:0] c_EXT_ZERO  = 2'd0;
    localparam logic [1:0] c_EXT_SIGN  = 2'd1;
    localparam logic [1:0] c_EXT_UPPER = 2'd2;

    localparam logic [1:0] c_NPC_PC4    = 2'd0;
    localparam logic [1:0] c_NPC_BRANCH = 2'd1;
    localparam logic [1:0] c_NPC_JUMP   = 2'd2;
    localparam logic [1:0] c_NPC_JR     = 2'd3;

    localparam logic [1:0] c_WD_ALU  = 2'd0;
    localparam logic [1:0] c_WD_DM   = 2'd1;
    localparam logic [1:0] c_WD_PC   = 2'd2;
    localparam logic [1:0] c_WD_HILO = 2'd3;

    localparam logic [1:0] c_RD_RT = 2'd0;
    localparam logic [1:0] c_RD_RD = 2'd1;
    localparam logic [1:0] c_RD_RA = 2'd2;

    // One-hot instruction classes; mdu covers all four mult/div forms,
    // div marks the long-latency subset.
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic mdu;
        logic div;
        logic mf;
        logic illegal;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_decode
//  Purpose  : Combinational opcode/func decode into instruction classes plus
//             the unsupported-encoding flag.
//  Revision : 1.0  initial release
// ============================================================================
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_func,
    output dec_t       o_dec
);

    // Classify the instruction; anything not recognised is illegal
    always_comb begin
        o_dec = '0;
        case (i_opcode)
            c_OP_RTYPE: begin
                case (i_func)
                    c_F_ADDU:             o_dec.addu = 1'b1;
                    c_F_SUBU:             o_dec.subu = 1'b1;
                    c_F_JR:               o_dec.jr   = 1'b1;
                    c_F_MFHI, c_F_MFLO:   o_dec.mf   = 1'b1;
                    c_F_MULT, c_F_MULTU:  o_dec.mdu  = 1'b1;
                    c_F_DIV, c_F_DIVU: begin
                        o_dec.mdu = 1'b1;
                        o_dec.div = 1'b1;
                    end
                    default:              o_dec.illegal = 1'b1;
                endcase
            end
            c_OP_ORI: o_dec.ori = 1'b1;
            c_OP_LUI: o_dec.lui = 1'b1;
            c_OP_LW:  o_dec.lw  = 1'b1;
            c_OP_SW:  o_dec.sw  = 1'b1;
            c_OP_BEQ: o_dec.beq = 1'b1;
            c_OP_J:   o_dec.j   = 1'b1;
            c_OP_JAL: o_dec.jal = 1'b1;
            default:  o_dec.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller
//  Purpose  : Multi-cycle MIPS-lite control FSM (FETCH/DECODE/EXE/MEM/WB)
//             with an MDU stall state of parametrised latency.
//  Revision : 1.0  initial release
// ============================================================================
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTR_W = 4,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                zero,
    output logic                pc_write,
    output logic                ir_write,
    output logic                regwrite,
    output logic                memwrite,
    output logic [1:0]          regdst,
    output logic [1:0]          wd_sel,
    output logic                alusrc,
    output logic [1:0]          extop,
    output logic [ALUCTR_W-1:0] aluctr,
    output logic [1:0]          npc_sel,
    output logic                mdu_start,
    output logic [1:0]          mdu_op,
    output logic                hilo_sel,
    output logic                busy,
    output logic                illegal,
    output logic [2:0]          state
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    dec_t             w_dec;

    logic       w_pc_write, w_ir_write, w_regwrite, w_memwrite;
    logic       w_mdu_start, w_busy, w_illegal;
    logic [1:0] w_alu_code;

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_func   (func),
        .o_dec    (w_dec)
    );

    // State sequencing and MDU busy counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_dec.j || w_dec.jal || w_dec.jr || w_dec.illegal)
                        r_state <= S_FETCH;
                    else
                        r_state <= S_EXE;
                end
                S_EXE: begin
                    if (w_dec.lw || w_dec.sw) begin
                        r_state <= S_MEM;
                    end else if (w_dec.beq) begin
                        r_state <= S_FETCH;
                    end else if (w_dec.mdu) begin
                        r_state <= S_MDU;
                        r_cnt   <= w_dec.div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM:    r_state <= w_dec.lw ? S_WB : S_FETCH;
                S_WB:     r_state <= S_FETCH;
                S_MDU: begin
                    if (r_cnt == '0)
                        r_state <= S_FETCH;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Per-state control decode; datapath selects persist from EXE through WB
    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_regwrite  = 1'b0;
        w_memwrite  = 1'b0;
        w_mdu_start = 1'b0;
        w_busy      = 1'b0;
        w_illegal   = 1'b0;
        w_alu_code  = c_ALU_ADD;
        regdst      = c_RD_RT;
        wd_sel      = c_WD_ALU;
        alusrc      = 1'b0;
        extop       = c_EXT_ZERO;
        npc_sel     = c_NPC_PC4;

        if (r_state == S_EXE || r_state == S_MEM || r_state == S_WB) begin
            if (w_dec.subu || w_dec.beq)
                w_alu_code = c_ALU_SUB;
            else if (w_dec.ori)
                w_alu_code = c_ALU_OR;
            else if (w_dec.lui)
                w_alu_code = c_ALU_LUI;
            alusrc = w_dec.ori || w_dec.lui || w_dec.lw || w_dec.sw;
            if (w_dec.lw || w_dec.sw || w_dec.beq)
                extop = c_EXT_SIGN;
            else if (w_dec.lui)
                extop = c_EXT_UPPER;
        end

        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
            end
            S_DECODE: begin
                w_illegal = w_dec.illegal;
                if (w_dec.j || w_dec.jal) begin
                    w_pc_write = 1'b1;
                    npc_sel    = c_NPC_JUMP;
                end
                if (w_dec.jal) begin
                    w_regwrite = 1'b1;
                    regdst     = c_RD_RA;
                    wd_sel     = c_WD_PC;
                end
                if (w_dec.jr) begin
                    w_pc_write = 1'b1;
                    npc_sel    = c_NPC_JR;
                end
            end
            S_EXE: begin
                if (w_dec.beq) begin
                    w_pc_write = zero;
                    npc_sel    = c_NPC_BRANCH;
                end
                w_mdu_start = w_dec.mdu;
            end
            S_MEM:    w_memwrite = w_dec.sw;
            S_WB: begin
                w_regwrite = 1'b1;
                if (w_dec.addu || w_dec.subu || w_dec.mf)
                    regdst = c_RD_RD;
                if (w_dec.mf)
                    wd_sel = c_WD_HILO;
                else if (w_dec.lw)
                    wd_sel = c_WD_DM;
            end
            S_MDU:    w_busy = 1'b1;
            default:  ;
        endcase
    end

    // Enables and pulses are held low for the whole time reset is asserted
    assign pc_write  = w_pc_write  & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign regwrite  = w_regwrite  & ~reset;
    assign memwrite  = w_memwrite  & ~reset;
    assign mdu_start = w_mdu_start & ~reset;
    assign busy      = w_busy      & ~reset;
    assign illegal   = w_illegal   & ~reset;

    assign aluctr   = ALUCTR_W'(w_alu_code);
    assign mdu_op   = func[1:0];
    assign hilo_sel = (func == c_F_MFHI);
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_controller
//  Purpose  : Randomised self-checking bench for mc_controller against an
//             instruction-level reference of the control sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_controller;

    localparam int c_MULT_LAT = 5;
    localparam int c_DIV_LAT  = 10;

    // Instruction kinds
    localparam int K_ADDU = 0,  K_SUBU = 1,  K_ORI = 2,   K_LUI = 3;
    localparam int K_LW = 4,    K_SW = 5,    K_BEQ = 6,   K_J = 7;
    localparam int K_JAL = 8,   K_JR = 9,    K_MULT = 10, K_MULTU = 11;
    localparam int K_DIV = 12,  K_DIVU = 13, K_MFHI = 14, K_MFLO = 15;
    localparam int K_ILL = 16;

    // Phases, numbered like the architectural state codes
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_MDU = 5;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, rw, mw;
        logic [1:0] rd, wd;
        logic       as;
        logic [1:0] ex;
        logic [3:0] alu;
        logic [1:0] npc;
        logic       ms;
        logic [1:0] mop;
        logic       hs, bz, il;
    } ov_t;

    logic       clk, reset, zero;
    logic [5:0] opcode, func;
    logic       pc_write, ir_write, regwrite, memwrite, alusrc;
    logic       mdu_start, hilo_sel, busy, illegal;
    logic [1:0] regdst, wd_sel, extop, npc_sel, mdu_op;
    logic [3:0] aluctr;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    mc_controller #(
        .ALUCTR_W (4),
        .MULT_LAT (c_MULT_LAT),
        .DIV_LAT  (c_DIV_LAT),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .func      (func),
        .zero      (zero),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .regwrite  (regwrite),
        .memwrite  (memwrite),
        .regdst    (regdst),
        .wd_sel    (wd_sel),
        .alusrc    (alusrc),
        .extop     (extop),
        .aluctr    (aluctr),
        .npc_sel   (npc_sel),
        .mdu_start (mdu_start),
        .mdu_op    (mdu_op),
        .hilo_sel  (hilo_sel),
        .busy      (busy),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ov_t observe();
        ov_t o;
        o.st  = state;    o.pcw = pc_write; o.irw = ir_write;
        o.rw  = regwrite; o.mw  = memwrite; o.rd  = regdst;
        o.wd  = wd_sel;   o.as  = alusrc;   o.ex  = extop;
        o.alu = aluctr;   o.npc = npc_sel;  o.ms  = mdu_start;
        o.mop = mdu_op;   o.hs  = hilo_sel; o.bz  = busy;
        o.il  = illegal;
        return o;
    endfunction

    // Expected control word for one cycle of an instruction (e) and the
    // fields the instruction set defines in that cycle (m).
    function automatic void exp_out(input int k, input int ph, input logic z,
                                    output ov_t e, output ov_t m);
        e = '0;
        m = '0;
        m.st = 3'h7; m.pcw = 1; m.irw = 1; m.rw = 1; m.mw = 1;
        m.ms = 1;    m.bz = 1;  m.il = 1;
        e.st = 3'(ph);
        // ALU-side selects: zero in FETCH, fixed by the instruction in EXE..WB
        if (ph == P_F) begin
            m.as = 1; m.ex = 2'h3; m.alu = 4'hf;
        end else if (ph >= P_E && ph <= P_W && k <= K_BEQ) begin
            m.as = 1; m.ex = 2'h3; m.alu = 4'hf;
            case (k)
                K_ADDU: e.alu = 0;
                K_SUBU: e.alu = 1;
                K_ORI:  begin e.alu = 2; e.as = 1; e.ex = 0; end
                K_LUI:  begin e.alu = 3; e.as = 1; e.ex = 2; end
                K_LW, K_SW: begin e.alu = 0; e.as = 1; e.ex = 1; end
                K_BEQ:  begin e.alu = 1; e.ex = 1; end
                default: ;
            endcase
        end
        case (ph)
            P_F: begin
                e.pcw = 1; e.irw = 1; m.npc = 2'h3;
            end
            P_D: begin
                if (k == K_J || k == K_JAL) begin
                    e.pcw = 1; e.npc = 2; m.npc = 2'h3;
                end
                if (k == K_JAL) begin
                    e.rw = 1; e.rd = 2; e.wd = 2; m.rd = 2'h3; m.wd = 2'h3;
                end
                if (k == K_JR) begin
                    e.pcw = 1; e.npc = 3; m.npc = 2'h3;
                end
                e.il = (k == K_ILL);
            end
            P_E: begin
                if (k == K_BEQ) begin
                    e.pcw = z; e.npc = 1; m.npc = 2'h3;
                end
                if (k >= K_MULT && k <= K_DIVU) begin
                    e.ms = 1; e.mop = 2'(k - K_MULT); m.mop = 2'h3;
                end
            end
            P_M: e.mw = (k == K_SW);
            P_W: begin
                e.rw = 1; m.rd = 2'h3; m.wd = 2'h3;
                case (k)
                    K_ADDU, K_SUBU: begin e.rd = 1; e.wd = 0; end
                    K_MFHI, K_MFLO: begin
                        e.rd = 1; e.wd = 3; m.hs = 1; e.hs = (k == K_MFHI);
                    end
                    K_LW:    begin e.rd = 0; e.wd = 1; end
                    default: begin e.rd = 0; e.wd = 0; end
                endcase
            end
            P_MDU: e.bz = 1;
            default: ;
        endcase
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h0d, 6'h0f, 6'h23, 6'h2b};
    endfunction

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn inside {6'h08, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h21, 6'h23};
    endfunction

    // Drive one instruction and check every cycle of it. zmode <0 randomises
    // zero each cycle; cut >0 stops after that many cycles.
    task automatic run_instr(input int k, input int zmode, input int cut);
        logic [5:0] op, fn;
        int ph[$];
        ov_t e, m, o;
        fn = 6'($urandom);
        case (k)
            K_ADDU:  begin op = 6'h00; fn = 6'h21; end
            K_SUBU:  begin op = 6'h00; fn = 6'h23; end
            K_ORI:   op = 6'h0d;
            K_LUI:   op = 6'h0f;
            K_LW:    op = 6'h23;
            K_SW:    op = 6'h2b;
            K_BEQ:   op = 6'h04;
            K_J:     op = 6'h02;
            K_JAL:   op = 6'h03;
            K_JR:    begin op = 6'h00; fn = 6'h08; end
            K_MULT:  begin op = 6'h00; fn = 6'h18; end
            K_MULTU: begin op = 6'h00; fn = 6'h19; end
            K_DIV:   begin op = 6'h00; fn = 6'h1a; end
            K_DIVU:  begin op = 6'h00; fn = 6'h1b; end
            K_MFHI:  begin op = 6'h00; fn = 6'h10; end
            K_MFLO:  begin op = 6'h00; fn = 6'h12; end
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    op = 6'($urandom);
                    if (legal_op(op)) op = 6'h3f;
                end else begin
                    op = 6'h00;
                    if (legal_fn(fn)) fn = 6'h3f;
                end
            end
        endcase
        opcode = op;
        func   = fn;

        ph.push_back(P_F);
        ph.push_back(P_D);
        if (!(k inside {K_J, K_JAL, K_JR, K_ILL})) ph.push_back(P_E);
        if (k == K_LW || k == K_SW) ph.push_back(P_M);
        if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_MFHI, K_MFLO}) ph.push_back(P_W);
        if (k == K_MULT || k == K_MULTU) repeat (c_MULT_LAT) ph.push_back(P_MDU);
        if (k == K_DIV || k == K_DIVU) repeat (c_DIV_LAT) ph.push_back(P_MDU);

        for (int i = 0; i < ph.size(); i++) begin
            if (cut > 0 && i >= cut) break;
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #2;
            exp_out(k, ph[i], zero, e, m);
            o = observe();
            chk($sformatf("k%0d_c%0d_p%0d", k, i, ph[i]), 32'(o & m), 32'(e & m));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ov_t o, mr;
        reset  = 1'b1;
        zero   = 1'b0;
        opcode = 6'h00;
        func   = 6'h21;
        mr = '0;
        mr.st = 3'h7; mr.pcw = 1; mr.irw = 1; mr.rw = 1; mr.mw = 1;
        mr.ms = 1;    mr.bz = 1;  mr.il = 1;

        repeat (3) @(posedge clk);
        #1;
        o = observe();
        chk("reset_state", 32'(o & mr), 32'(0));
        reset = 1'b0;

        // Directed sequence covering the key instruction shapes
        run_instr(K_ADDU, -1, 0);
        run_instr(K_LW,   -1, 0);
        run_instr(K_SW,   -1, 0);
        run_instr(K_BEQ,   1, 0);
        run_instr(K_BEQ,   0, 0);
        run_instr(K_MULT, -1, 0);
        run_instr(K_MFHI, -1, 0);
        run_instr(K_DIVU, -1, 0);
        run_instr(K_JAL,  -1, 0);
        opcode = 6'h3f;
        run_instr(K_ILL,  -1, 0);

        // Reset asserted while a store sits in MEM
        run_instr(K_SW, -1, 3);
        #2;
        chk("sw_mem_state", 32'(state), 32'(3));
        chk("sw_mem_write", 32'(memwrite), 32'(1));
        reset = 1'b1;
        #1;
        o = observe();
        chk("rst_mid_sw", 32'(o & mr), 32'(0));
        @(posedge clk);
        #1;
        o = observe();
        chk("rst_hold", 32'(o & mr), 32'(0));
        reset = 1'b0;
        #1;
        chk("rel_state", 32'(state), 32'(0));
        chk("rel_fetch", 32'({ir_write, pc_write, memwrite, regwrite}), 32'(4'b1100));
        @(posedge clk);
        #1;
        chk("rel_decode", 32'({state, memwrite}), 32'({3'd1, 1'b0}));
        // The sw is still in IR; let it finish from DECODE onward unchecked
        // by restarting at a clean FETCH boundary.
        while (state != 3'd0) begin
            @(posedge clk);
            #1;
        end

        // Randomised instruction stream
        for (int n = 0; n < 200; n++) begin
            run_instr(int'($urandom_range(0, 16)), -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so a stuck FSM cannot hang the run
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
